// File: rtl/sd_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SD host register block.
// Holds the grant for whole and locked cycles; a watchdog ends stalled strobes with ERR.
module sd_wb_arbiter #(
  parameter int gWidth   = 32,
  parameter int gTimeout = 255
) (
  input  logic              CLK_I,
  input  logic              RST_I,

  input  logic              m0_CYC_I,
  input  logic              m0_STB_I,
  input  logic              m0_WE_I,
  input  logic              m0_LOCK_I,
  input  logic [2:0]        m0_ADR_I,
  input  logic [gWidth-1:0] m0_DAT_I,
  input  logic              m0_SEL_I,
  input  logic [2:0]        m0_CTI_I,
  output logic              m0_ACK_O,
  output logic              m0_ERR_O,
  output logic              m0_RTY_O,
  output logic [gWidth-1:0] m0_DAT_O,

  input  logic              m1_CYC_I,
  input  logic              m1_STB_I,
  input  logic              m1_WE_I,
  input  logic              m1_LOCK_I,
  input  logic [2:0]        m1_ADR_I,
  input  logic [gWidth-1:0] m1_DAT_I,
  input  logic              m1_SEL_I,
  input  logic [2:0]        m1_CTI_I,
  output logic              m1_ACK_O,
  output logic              m1_ERR_O,
  output logic              m1_RTY_O,
  output logic [gWidth-1:0] m1_DAT_O,

  output logic              s_CYC_O,
  output logic              s_STB_O,
  output logic              s_WE_O,
  output logic              s_LOCK_O,
  output logic [2:0]        s_ADR_O,
  output logic [gWidth-1:0] s_DAT_O,
  output logic              s_SEL_O,
  output logic [2:0]        s_CTI_O,
  input  logic              s_ACK_I,
  input  logic              s_ERR_I,
  input  logic              s_RTY_I,
  input  logic [gWidth-1:0] s_DAT_I,

  output logic [1:0]        gnt_O,
  output logic              timeout_O
);

  // state | meaning
  // IDLE  | no owner, slave outputs forced low, arbitration happens here
  // OWN0  | master 0 owns the slave port (CYC or LOCK held)
  // OWN1  | master 1 owns the slave port (CYC or LOCK held)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [15:0] TermCnt = 16'(gTimeout - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q;

  logic own0, own1, own_stb, resp, expire;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 2'b00;
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      timeout_q <= expire;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        // On a tie the master that did not own the port last wins.
        if (m0_CYC_I && (!m1_CYC_I || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
          gnt_d   = 2'b01;
        end else if (m1_CYC_I) begin
          state_d = OWN1;
          last_d  = 1'b1;
          gnt_d   = 2'b10;
        end
      end
      OWN0: begin
        if (!(m0_CYC_I || m0_LOCK_I)) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
      end
      OWN1: begin
        if (!(m1_CYC_I || m1_LOCK_I)) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Ownership is masked by reset so every output drops without waiting for a clock.
  assign own0 = (state_q == OWN0) && !RST_I;
  assign own1 = (state_q == OWN1) && !RST_I;

  assign own_stb = (own0 && m0_STB_I) || (own1 && m1_STB_I);
  assign resp    = s_ACK_I || s_ERR_I || s_RTY_I;
  assign expire  = own_stb && !resp && (cnt_q == TermCnt);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!own_stb || resp || expire) begin
      cnt_d = 16'd0;
    end
  end

  always_comb begin
    s_CYC_O  = 1'b0;
    s_STB_O  = 1'b0;
    s_WE_O   = 1'b0;
    s_LOCK_O = 1'b0;
    s_ADR_O  = 3'd0;
    s_DAT_O  = '0;
    s_SEL_O  = 1'b0;
    s_CTI_O  = 3'd0;
    if (own0) begin
      s_CYC_O  = m0_CYC_I;
      s_STB_O  = m0_STB_I && !expire;
      s_WE_O   = m0_WE_I;
      s_LOCK_O = m0_LOCK_I;
      s_ADR_O  = m0_ADR_I;
      s_DAT_O  = m0_DAT_I;
      s_SEL_O  = m0_SEL_I;
      s_CTI_O  = m0_CTI_I;
    end else if (own1) begin
      s_CYC_O  = m1_CYC_I;
      s_STB_O  = m1_STB_I && !expire;
      s_WE_O   = m1_WE_I;
      s_LOCK_O = m1_LOCK_I;
      s_ADR_O  = m1_ADR_I;
      s_DAT_O  = m1_DAT_I;
      s_SEL_O  = m1_SEL_I;
      s_CTI_O  = m1_CTI_I;
    end
  end

  assign m0_ACK_O = own0 && s_ACK_I;
  assign m0_RTY_O = own0 && s_RTY_I;
  assign m0_ERR_O = own0 && (s_ERR_I || expire);
  assign m0_DAT_O = own0 ? s_DAT_I : '0;

  assign m1_ACK_O = own1 && s_ACK_I;
  assign m1_RTY_O = own1 && s_RTY_I;
  assign m1_ERR_O = own1 && (s_ERR_I || expire);
  assign m1_DAT_O = own1 ? s_DAT_I : '0;

  assign gnt_O     = gnt_q;
  assign timeout_O = timeout_q;

endmodule

// File: tb/tb_sd_wb_arbiter.sv
// Directed bench for sd_wb_arbiter: expected responses are queued when a slave reply is
// driven and checked against whichever master the DUT routes it to.
module tb_sd_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  m_cyc, m_stb, m_we, m_lock, m_sel;
  logic [2:0]  m_adr [2];
  logic [31:0] m_dat [2];
  logic [2:0]  m_cti [2];

  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [31:0] m0_dato, m1_dato;

  logic        s_cyc, s_stb, s_we, s_lock, s_sel;
  logic [2:0]  s_adr, s_cti;
  logic [31:0] s_dato;
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dati;

  logic [1:0]  gnt;
  logic        tmo;

  int total = 0;
  int bad   = 0;
  logic [34:0] sb_q [$];

  sd_wb_arbiter #(.gWidth(32), .gTimeout(4)) dut (
    .CLK_I(clk), .RST_I(rst),
    .m0_CYC_I(m_cyc[0]), .m0_STB_I(m_stb[0]), .m0_WE_I(m_we[0]), .m0_LOCK_I(m_lock[0]),
    .m0_ADR_I(m_adr[0]), .m0_DAT_I(m_dat[0]), .m0_SEL_I(m_sel[0]), .m0_CTI_I(m_cti[0]),
    .m0_ACK_O(m0_ack), .m0_ERR_O(m0_err), .m0_RTY_O(m0_rty), .m0_DAT_O(m0_dato),
    .m1_CYC_I(m_cyc[1]), .m1_STB_I(m_stb[1]), .m1_WE_I(m_we[1]), .m1_LOCK_I(m_lock[1]),
    .m1_ADR_I(m_adr[1]), .m1_DAT_I(m_dat[1]), .m1_SEL_I(m_sel[1]), .m1_CTI_I(m_cti[1]),
    .m1_ACK_O(m1_ack), .m1_ERR_O(m1_err), .m1_RTY_O(m1_rty), .m1_DAT_O(m1_dato),
    .s_CYC_O(s_cyc), .s_STB_O(s_stb), .s_WE_O(s_we), .s_LOCK_O(s_lock),
    .s_ADR_O(s_adr), .s_DAT_O(s_dato), .s_SEL_O(s_sel), .s_CTI_O(s_cti),
    .s_ACK_I(s_ack), .s_ERR_I(s_err), .s_RTY_I(s_rty), .s_DAT_I(s_dati),
    .gnt_O(gnt), .timeout_O(tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int n, input logic cyc, input logic stb, input logic we,
                     input logic lock, input logic [2:0] adr, input logic [31:0] dat,
                     input logic [2:0] cti);
    m_cyc[n]  = cyc;
    m_stb[n]  = stb;
    m_we[n]   = we;
    m_lock[n] = lock;
    m_adr[n]  = adr;
    m_dat[n]  = dat;
    m_cti[n]  = cti;
    m_sel[n]  = stb;
  endtask

  // who: 2'b01 = master 0, 2'b10 = master 1
  task automatic push(input logic [1:0] who, input logic err, input logic [31:0] dat);
    sb_q.push_back({who, err, dat});
  endtask

  always @(negedge clk) begin
    logic [34:0] obs;
    logic [34:0] exp;
    if (m0_ack || m0_err || m1_ack || m1_err) begin
      obs = {m1_ack | m1_err, m0_ack | m0_err, m0_err | m1_err,
             (m1_ack | m1_err) ? m1_dato : m0_dato};
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_unexpected observed=%h expected=none", obs);
      end else begin
        exp = sb_q.pop_front();
        chk("sb_resp", obs, exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_lock = '0; m_sel = '0;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_cti[i] = '0;
    end
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dati = '0;
    #2;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_tmo", tmo, 0);
    step(); step();
    rst = 1'b0;

    // contest from reset: m0 first, one idle cycle, then m1
    step();
    drv(0, 1, 1, 1, 0, 3'd1, 32'h0000_00D0, 3'b000);
    drv(1, 1, 1, 1, 0, 3'd2, 32'h0000_00D1, 3'b000);
    #1 chk("c1_pre_gnt", gnt, 2'b00);
    step();
    s_ack = 1'b1; push(2'b01, 0, 32'h0);
    #1 chk("c1_gnt0", gnt, 2'b01);
    chk("c1_sdat0", s_dato, 32'h0000_00D0);
    chk("c1_sadr0", s_adr, 3'd1);
    chk("c1_m1_ack", m1_ack, 0);
    step();
    s_ack = 1'b0; drv(0, 0, 0, 0, 0, 3'd0, 32'h0, 3'b000);
    #1 chk("c1_rel_gnt", gnt, 2'b01);
    step();
    #1 chk("c1_gap_gnt", gnt, 2'b00);
    chk("c1_gap_scyc", s_cyc, 0);
    step();
    s_ack = 1'b1; push(2'b10, 0, 32'h0);
    #1 chk("c1_gnt1", gnt, 2'b10);
    chk("c1_sdat1", s_dato, 32'h0000_00D1);
    chk("c1_sadr1", s_adr, 3'd2);
    step();
    s_ack = 1'b0; drv(1, 0, 0, 0, 0, 3'd0, 32'h0, 3'b000);
    step();
    #1 chk("c1_end_gnt", gnt, 2'b00);

    // single m0 read, two wait states
    step();
    drv(0, 1, 1, 0, 0, 3'b010, 32'h0, 3'b000);
    #1 chk("rd_pre_gnt", gnt, 2'b00);
    step();
    #1 chk("rd_gnt", gnt, 2'b01);
    chk("rd_scyc", s_cyc, 1);
    chk("rd_sadr", s_adr, 3'b010);
    chk("rd_swe", s_we, 0);
    step(); step();
    s_ack = 1'b1; s_dati = 32'hA5A5_0001; push(2'b01, 0, 32'hA5A5_0001);
    #1 chk("rd_m0_ack", m0_ack, 1);
    chk("rd_m1_ack", m1_ack, 0);
    chk("rd_m1_dat", m1_dato, 32'h0);
    step();
    s_ack = 1'b0; s_dati = '0; drv(0, 0, 0, 0, 0, 3'd0, 32'h0, 3'b000);
    step();
    #1 chk("rd_end_gnt", gnt, 2'b00);

    // second contest: m0 owned last, so m1 wins this time
    drv(0, 1, 1, 1, 0, 3'd3, 32'h0000_00E0, 3'b000);
    drv(1, 1, 1, 1, 0, 3'd4, 32'h0000_00E1, 3'b000);
    step();
    s_ack = 1'b1; push(2'b10, 0, 32'h0);
    #1 chk("c2_gnt1", gnt, 2'b10);
    chk("c2_sdat1", s_dato, 32'h0000_00E1);
    chk("c2_m0_ack", m0_ack, 0);
    step();
    s_ack = 1'b0; drv(1, 0, 0, 0, 0, 3'd0, 32'h0, 3'b000);
    step();
    #1 chk("c2_gap_gnt", gnt, 2'b00);
    step();
    s_ack = 1'b1; push(2'b01, 0, 32'h0);
    #1 chk("c2_gnt0", gnt, 2'b01);
    chk("c2_sdat0", s_dato, 32'h0000_00E0);
    step();
    s_ack = 1'b0; drv(0, 0, 0, 0, 0, 3'd0, 32'h0, 3'b000);
    step();

    // lock: m0 keeps the port with CYC low while m1 waits
    drv(0, 1, 1, 1, 1, 3'd5, 32'h0000_10CC, 3'b000);
    step();
    s_ack = 1'b1; push(2'b01, 0, 32'h0);
    drv(1, 1, 0, 0, 0, 3'd6, 32'h0, 3'b000);
    #1 chk("lk_gnt", gnt, 2'b01);
    chk("lk_slock", s_lock, 1);
    step();
    s_ack = 1'b0; drv(0, 0, 0, 0, 1, 3'd5, 32'h0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #1 chk("lk_hold_gnt", gnt, 2'b01);
      chk("lk_hold_scyc", s_cyc, 0);
      chk("lk_hold_slock", s_lock, 1);
      step();
    end
    drv(0, 1, 0, 0, 1, 3'd5, 32'h0, 3'b000);
    #1 chk("lk_recyc_gnt", gnt, 2'b01);
    chk("lk_recyc_scyc", s_cyc, 1);
    step();
    drv(0, 0, 0, 0, 0, 3'd0, 32'h0, 3'b000);
    #1 chk("lk_unlock_gnt", gnt, 2'b01);
    step();
    #1 chk("lk_idle_gnt", gnt, 2'b00);
    step();
    #1 chk("lk_m1_gnt", gnt, 2'b10);

    // watchdog: m1 strobes, slave silent, ERR in the 4th strobe cycle
    drv(1, 1, 1, 0, 0, 3'd6, 32'h0, 3'b000);
    #1 chk("wd_c1_err", m1_err, 0);
    chk("wd_c1_sstb", s_stb, 1);
    step(); step();
    #1 chk("wd_c3_err", m1_err, 0);
    step();
    push(2'b10, 1, 32'h0);
    #1 chk("wd_c4_sstb", s_stb, 0);
    chk("wd_c4_err", m1_err, 1);
    chk("wd_c4_tmo", tmo, 0);
    step();
    drv(1, 1, 0, 0, 0, 3'd6, 32'h0, 3'b000);
    #1 chk("wd_tmo_pulse", tmo, 1);
    chk("wd_c5_err", m1_err, 0);
    step();
    #1 chk("wd_tmo_end", tmo, 0);

    // watchdog: ACK in the 4th strobe cycle wins over expiry
    drv(1, 1, 1, 0, 0, 3'd6, 32'h0, 3'b000);
    step(); step(); step();
    s_ack = 1'b1; s_dati = 32'h0000_ACED; push(2'b10, 0, 32'h0000_ACED);
    #1 chk("wa_err", m1_err, 0);
    chk("wa_sstb", s_stb, 1);
    chk("wa_ack", m1_ack, 1);
    step();
    s_ack = 1'b0; s_dati = '0; drv(1, 0, 0, 0, 0, 3'd0, 32'h0, 3'b000);
    #1 chk("wa_tmo", tmo, 0);
    step();

    // incrementing burst on m0
    drv(0, 1, 1, 0, 0, 3'd0, 32'h0, 3'b010);
    step();
    for (int i = 0; i < 4; i++) begin
      m_adr[0] = i[2:0];
      m_cti[0] = (i == 3) ? 3'b111 : 3'b010;
      s_ack = 1'b1; s_dati = 32'hB000_0000 + i;
      push(2'b01, 0, 32'hB000_0000 + i);
      #1 chk("bu_gnt", gnt, 2'b01);
      chk("bu_scti", s_cti, (i == 3) ? 3'b111 : 3'b010);
      step();
    end
    s_ack = 1'b0; s_dati = '0; drv(0, 0, 0, 0, 0, 3'd0, 32'h0, 3'b000);
    #1 chk("bu_last_gnt", gnt, 2'b01);
    step();
    #1 chk("bu_rel_gnt", gnt, 2'b00);

    // reset during m1 write wait state
    drv(1, 1, 1, 1, 0, 3'd7, 32'h0000_7777, 3'b000);
    step();
    #1 chk("rs_gnt1", gnt, 2'b10);
    drv(0, 1, 1, 1, 0, 3'd3, 32'h0000_3333, 3'b000);
    #1 rst = 1'b1;
    #1 chk("rs_gnt", gnt, 2'b00);
    chk("rs_scyc", s_cyc, 0);
    chk("rs_sstb", s_stb, 0);
    chk("rs_sdat", s_dato, 32'h0);
    chk("rs_tmo", tmo, 0);
    step(); step();
    rst = 1'b0;
    step();
    #1 chk("rs_after_gnt", gnt, 2'b01);
    drv(0, 0, 0, 0, 0, 3'd0, 32'h0, 3'b000);
    drv(1, 0, 0, 0, 0, 3'd0, 32'h0, 3'b000);
    step(); step();
    chk("sb_drain", 35'(sb_q.size()), 35'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
